// File: rtl/mandelbrot_scheduler.sv
// Dynamic scheduler for a pool of Mandelbrot engines: issues pixels in raster order to idle engines
// and re-serialises out-of-order iteration counts through a reorder buffer into a raster pixel stream.
//   state   | meaning
//   S_IDLE  | waiting for frame_start
//   S_RUN   | issuing pixels, collecting completions, streaming output
//   S_DRAIN | every pixel issued; streaming out the remaining ROB entries
module mandelbrot_scheduler #(
    parameter int NUM_ENGINES = 12,
    parameter int X_SIZE      = 640,
    parameter int Y_SIZE      = 480,
    parameter int PIXEL_W     = 10,
    parameter int ITER_W      = 32,
    parameter int ROB_DEPTH   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_start,
    output logic [NUM_ENGINES-1:0]         eng_start,
    output logic [NUM_ENGINES*PIXEL_W-1:0] eng_x,
    output logic [NUM_ENGINES*PIXEL_W-1:0] eng_y,
    input  logic [NUM_ENGINES-1:0]         eng_done,
    input  logic [NUM_ENGINES*ITER_W-1:0]  eng_iter,
    output logic [ITER_W-1:0]              out_iter,
    output logic [PIXEL_W-1:0]             out_x,
    output logic [PIXEL_W-1:0]             out_y,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           first,
    output logic                           last_x,
    output logic                           last_y,
    output logic                           frame_busy
);
    localparam int IDX_W = $clog2(ROB_DEPTH);
    localparam int SEQ_W = IDX_W + 1;
    localparam int ENG_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [PIXEL_W-1:0] X_LAST = PIXEL_W'(X_SIZE - 1);
    localparam logic [PIXEL_W-1:0] Y_LAST = PIXEL_W'(Y_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
    state_t state, state_nxt;

    logic [PIXEL_W-1:0]   iss_x, iss_y, pop_x, pop_y;
    logic [SEQ_W-1:0]     iss_seq, pop_seq;
    logic [NUM_ENGINES-1:0] busy;
    logic [IDX_W-1:0]     tag [NUM_ENGINES];
    logic [ITER_W-1:0]    rob_iter [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] rob_vld;
    logic [IDX_W-1:0]     head;
    logic [ENG_W-1:0]     issue_idx;
    logic rob_full, any_idle, issue_en, pop_en, iss_last, pop_last;

    // Full when the wrap bits differ but the entry indices coincide.
    assign rob_full = (iss_seq[SEQ_W-1] != pop_seq[SEQ_W-1]) &&
                      (iss_seq[IDX_W-1:0] == pop_seq[IDX_W-1:0]);
    assign head     = pop_seq[IDX_W-1:0];
    assign iss_last = (iss_x == X_LAST) && (iss_y == Y_LAST);
    assign pop_last = (pop_x == X_LAST) && (pop_y == Y_LAST);
    assign issue_en = (state == S_RUN) && any_idle && !rob_full;
    assign pop_en   = out_valid && out_ready;

    assign out_valid  = rob_vld[head];
    assign out_iter   = out_valid ? rob_iter[head] : '0;
    assign out_x      = pop_x;
    assign out_y      = pop_y;
    assign first      = out_valid && (pop_x == '0) && (pop_y == '0);
    assign last_x     = out_valid && (pop_x == X_LAST);
    assign last_y     = out_valid && pop_last;
    assign frame_busy = (state != S_IDLE);

    always_comb begin
        issue_idx = '0;
        any_idle  = 1'b0;
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                issue_idx = ENG_W'(i);
                any_idle  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (frame_start)        state_nxt = S_RUN;
            S_RUN:   if (issue_en && iss_last) state_nxt = S_DRAIN;
            S_DRAIN: if (pop_en && pop_last)   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            eng_start <= '0;
            eng_x     <= '0;
            eng_y     <= '0;
            iss_x     <= '0;
            iss_y     <= '0;
            pop_x     <= '0;
            pop_y     <= '0;
            iss_seq   <= '0;
            pop_seq   <= '0;
            busy      <= '0;
            rob_vld   <= '0;
            for (int i = 0; i < NUM_ENGINES; i++) tag[i] <= '0;
        end else begin
            eng_start <= '0;
            if (issue_en) begin
                eng_start[issue_idx]                   <= 1'b1;
                eng_x[issue_idx*PIXEL_W +: PIXEL_W]    <= iss_x;
                eng_y[issue_idx*PIXEL_W +: PIXEL_W]    <= iss_y;
                busy[issue_idx]                        <= 1'b1;
                tag[issue_idx]                         <= iss_seq[IDX_W-1:0];
                iss_seq                                <= iss_seq + SEQ_W'(1);
                if (iss_x == X_LAST) begin
                    iss_x <= '0;
                    iss_y <= (iss_y == Y_LAST) ? '0 : iss_y + PIXEL_W'(1);
                end else begin
                    iss_x <= iss_x + PIXEL_W'(1);
                end
            end
            if (pop_en) begin
                rob_vld[head] <= 1'b0;
                pop_seq       <= pop_seq + SEQ_W'(1);
                if (pop_x == X_LAST) begin
                    pop_x <= '0;
                    pop_y <= (pop_y == Y_LAST) ? '0 : pop_y + PIXEL_W'(1);
                end else begin
                    pop_x <= pop_x + PIXEL_W'(1);
                end
            end
            // A completing entry can never be the head being popped, so these writes never collide.
            for (int i = 0; i < NUM_ENGINES; i++) begin
                if (eng_done[i] && busy[i]) begin
                    rob_vld[tag[i]]  <= 1'b1;
                    rob_iter[tag[i]] <= eng_iter[i*ITER_W +: ITER_W];
                    busy[i]          <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mandelbrot_scheduler.sv
// Scoreboard bench for mandelbrot_scheduler: behavioural engines with programmable latency, random
// iteration counts, and a raster-order reference queue checked by an independent output monitor.
module tb_mandelbrot_scheduler;
    localparam int N = 3, XS = 4, YS = 3, PW = 4, IW = 16, RD = 4, NPIX = XS * YS;

    logic clk = 1'b0, reset = 1'b1, frame_start = 1'b0, out_ready = 1'b1;
    logic [N-1:0]    eng_start;
    logic [N-1:0]    eng_done = '0;
    logic [N*PW-1:0] eng_x, eng_y;
    logic [N*IW-1:0] eng_iter = '0;
    logic [IW-1:0]   out_iter;
    logic [PW-1:0]   out_x, out_y;
    logic out_valid, first, last_x, last_y, frame_busy;

    mandelbrot_scheduler #(.NUM_ENGINES(N), .X_SIZE(XS), .Y_SIZE(YS), .PIXEL_W(PW),
                           .ITER_W(IW), .ROB_DEPTH(RD)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
        .eng_done(eng_done), .eng_iter(eng_iter),
        .out_iter(out_iter), .out_x(out_x), .out_y(out_y), .out_valid(out_valid),
        .out_ready(out_ready), .first(first), .last_x(last_x), .last_y(last_y),
        .frame_busy(frame_busy));

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model state
    int          exp_q[$];
    bit          model_busy = 1'b0;
    int          frame_beats = 0, iss_cnt = 0, triple_cnt = 0, cyc = 0;
    logic [IW-1:0] pix_iter [NPIX];
    int          beat_t [NPIX];
    int          lat [N];
    int          cnt [N];
    bit          running [N];

    // Behavioural engines; also checks that issues follow raster order to idle engines.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            eng_done = '0;
            for (int i = 0; i < N; i++) running[i] = 1'b0;
            iss_cnt = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (eng_done[i]) begin
                    eng_done[i] = 1'b0;
                    running[i]  = 1'b0;
                end else if (running[i]) begin
                    cnt[i]--;
                    if (cnt[i] == 0) eng_done[i] = 1'b1;
                end
            end
            if (&eng_done) triple_cnt++;
            for (int i = 0; i < N; i++) begin
                if (eng_start[i]) begin
                    chk("issue_to_idle_engine", int'(running[i]), 0);
                    chk("issue_within_frame", int'(iss_cnt < NPIX), 1);
                    chk("issue_x", int'(eng_x[i*PW +: PW]), iss_cnt % XS);
                    chk("issue_y", int'(eng_y[i*PW +: PW]), (iss_cnt / XS) % YS);
                    pix_iter[iss_cnt % NPIX] = IW'($urandom);
                    eng_iter[i*IW +: IW]     = pix_iter[iss_cnt % NPIX];
                    running[i] = 1'b1;
                    cnt[i]     = lat[i];
                    iss_cnt++;
                end
            end
        end
    end

    // Output monitor: pops the reference queue on every accepted beat and checks stall stability.
    logic [27:0] hold_vec;
    bit          prev_stall = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold_stable", int'({out_valid, first, last_x, last_y, out_x, out_y, out_iter}),
                    int'(hold_vec));
            prev_stall = out_valid && !out_ready;
            hold_vec   = {out_valid, first, last_x, last_y, out_x, out_y, out_iter};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    int idx;
                    idx = exp_q.pop_front();
                    chk("out_x", int'(out_x), idx % XS);
                    chk("out_y", int'(out_y), idx / XS);
                    chk("out_iter", int'(out_iter), int'(pix_iter[idx]));
                    chk("flags_first_lastx_lasty", int'({first, last_x, last_y}),
                        int'({idx == 0, (idx % XS) == XS - 1, idx == NPIX - 1}));
                    beat_t[frame_beats] = cyc;
                    frame_beats++;
                    if (idx == NPIX - 1) model_busy = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        if (!model_busy) begin
            for (int k = 0; k < NPIX; k++) exp_q.push_back(k);
            model_busy  = 1'b1;
            frame_beats = 0;
            iss_cnt     = 0;
        end
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_frame(input int budget, input bit rnd);
        int c;
        c = 0;
        while (model_busy && c < budget) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            tick();
            c++;
        end
        out_ready = 1'b1;
        chk("frame_complete_in_budget", int'(model_busy), 0);
        @(negedge clk);
        chk("frame_busy_after_last", int'(frame_busy), 0);
    endtask

    initial begin
        int c;
        lat = '{10, 2, 5};
        reset = 1'b1;
        frame_start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_eng_start", int'(eng_start), 0);
        chk("rst_eng_xy", int'({eng_x, eng_y}), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'({out_iter, out_x, out_y}), 0);
        chk("rst_flags", int'({first, last_x, last_y}), 0);
        chk("rst_frame_busy", int'(frame_busy), 0);

        // Release reset and start the frame (latencies 10/2/5, out_ready=1)
        tick();
        reset = 1'b0;
        start_frame();
        c = 0;
        while (eng_start == '0 && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("first_issue_eng_start", int'(eng_start), 1);
        chk("first_issue_xy", int'({eng_x[PW-1:0], eng_y[PW-1:0]}), 0);
        wait_frame(300, 1'b0);
        chk("beats_frame1", frame_beats, NPIX);

        // Backpressure: out_ready low for 30 cycles
        tick();
        out_ready = 1'b0;
        start_frame();
        repeat (30) tick();
        chk("stall_issue_count", iss_cnt, RD);
        @(negedge clk);
        chk("stall_out_valid", int'(out_valid), 1);
        chk("stall_head_xy", int'({out_x, out_y}), 0);
        tick();
        out_ready = 1'b1;
        wait_frame(300, 1'b0);
        chk("beats_stall_frame", frame_beats, NPIX);

        // Simultaneous completions of all three engines
        tick();
        lat = '{6, 5, 4};
        triple_cnt = 0;
        start_frame();
        wait_frame(300, 1'b0);
        chk("triple_done_seen", int'(triple_cnt > 0), 1);
        chk("consecutive_beats_0_2", beat_t[2] - beat_t[0], 2);

        // frame_start pulsed mid-RUN is ignored
        tick();
        lat = '{3, 7, 4};
        start_frame();
        repeat (8) tick();
        start_frame();
        wait_frame(300, 1'b0);
        repeat (20) tick();
        chk("beats_after_midrun_start", frame_beats, NPIX);
        start_frame();
        wait_frame(300, 1'b0);
        chk("beats_second_frame", frame_beats, NPIX);

        // Reset mid-frame after 5 beats
        tick();
        start_frame();
        c = 0;
        while (frame_beats < 5 && c < 300) begin
            tick();
            c++;
        end
        chk("reached_5_beats", int'(frame_beats >= 5), 1);
        reset = 1'b1;
        exp_q.delete();
        model_busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_frame_busy", int'(frame_busy), 0);
        chk("midrst_eng_start", int'(eng_start), 0);
        tick();
        reset = 1'b0;
        tick();
        start_frame();
        wait_frame(300, 1'b0);
        chk("beats_after_reset", frame_beats, NPIX);

        // Randomised latencies and backpressure
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) lat[i] = $urandom_range(1, 12);
            tick();
            start_frame();
            wait_frame(800, 1'b1);
            chk("beats_random_frame", frame_beats, NPIX);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end
endmodule
